// File: rtl/negate_serial_unit_if.sv
// Handshake bundle for negate_serial_unit: operand/mode in, result/overflow out.
// master drives operands and consumes results; slave is the unit itself.
interface negate_serial_unit_if #(
    parameter int unsigned W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [1:0]   in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_ovf;

    modport master (
        output in_valid, in_a, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/negate_serial_unit.sv
// Multi-cycle two's-complement pass/negate/abs unit, C bits per cycle, LSB chunk first.
// Optional feature: define NEG_SAT_EN to saturate the most-negative overflow to the max positive.
module negate_serial_unit #(
    parameter int unsigned W = 8,
    parameter int unsigned C = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    negate_serial_unit_if.slave  bus
);
    localparam int unsigned NCHUNK = W / C;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [W-1:0] NegMin = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] PosMax = ~NegMin;

    if (C < 1 || C > W || (W % C) != 0 || W < 2) begin : g_bad_cfg
        $error("negate_serial_unit: C must divide W with 1 <= C <= W and W >= 2");
    end

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic          neg_q, neg_d;
    logic          ovf_pend_q, ovf_pend_d;
    logic [W-1:0]  a_q, a_d;        // operand, shifted right one chunk per BUSY cycle
    logic [W-1:0]  acc_q, acc_d;    // result, filled from the top and shifted down
    logic [W-1:0]  data_q, data_d;
    logic          ovf_q, ovf_d;

    logic [C-1:0]  chunk;
    logic [C:0]    sum;
    logic          in_neg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            neg_q      <= 1'b0;
            ovf_pend_q <= 1'b0;
            a_q        <= '0;
            acc_q      <= '0;
            data_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            neg_q      <= neg_d;
            ovf_pend_q <= ovf_pend_d;
            a_q        <= a_d;
            acc_q      <= acc_d;
            data_q     <= data_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        neg_d      = neg_q;
        ovf_pend_d = ovf_pend_q;
        a_d        = a_q;
        acc_d      = acc_q;
        data_d     = data_q;
        ovf_d      = ovf_q;

        in_neg = (bus.in_mode == 2'b01) || (bus.in_mode == 2'b10 && bus.in_a[W-1]);
        chunk  = neg_q ? ~a_q[C-1:0] : a_q[C-1:0];
        sum    = {1'b0, chunk} + {{C{1'b0}}, carry_q};

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d        = bus.in_a;
                    neg_d      = in_neg;
                    carry_d    = in_neg;
                    ovf_pend_d = in_neg && (bus.in_a == NegMin);
                    cnt_d      = '0;
                    state_d    = StBusy;
                end
            end
            StBusy: begin
                acc_d   = (acc_q >> C) | (W'(sum[C-1:0]) << (W - C));
                a_d     = a_q >> C;
                carry_d = sum[C];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(NCHUNK - 1)) begin
                    state_d = StDone;
                    ovf_d   = ovf_pend_q;
`ifdef NEG_SAT_EN
                    data_d  = ovf_pend_q ? PosMax : acc_d;
`else
                    // Wrapped result of negating NegMin is NegMin itself.
                    data_d  = acc_d;
`endif
                end
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.out_data  = data_q;
    assign bus.out_ovf   = ovf_q;

`ifndef NEG_SAT_EN
    logic unused_posmax;
    assign unused_posmax = ^PosMax;
`endif
endmodule

// File: tb/tb_negate_serial_unit.sv
// Bench for negate_serial_unit: directed vectors on W=8/C=4 plus sweeps over four configurations.
// An arithmetic model plus a per-cycle handshake model checks every instance.
module tb_negate_serial_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    negate_serial_unit_if #(.W(8))  bus0 ();
    negate_serial_unit_if #(.W(8))  bus1 ();
    negate_serial_unit_if #(.W(8))  bus2 ();
    negate_serial_unit_if #(.W(16)) bus3 ();

    negate_serial_unit #(.W(8),  .C(4)) dut    (.clk(clk), .rst_n(rst_n), .bus(bus0));
    negate_serial_unit #(.W(8),  .C(1)) u_c1   (.clk(clk), .rst_n(rst_n), .bus(bus1));
    negate_serial_unit #(.W(8),  .C(8)) u_c8   (.clk(clk), .rst_n(rst_n), .bus(bus2));
    negate_serial_unit #(.W(16), .C(4)) u_w16  (.clk(clk), .rst_n(rst_n), .bus(bus3));

    int          nch[4] = '{2, 8, 1, 4};
    int          wid[4] = '{8, 8, 8, 16};
    bit          pend[4] = '{0, 0, 0, 0};
    int          age[4];
    logic [15:0] ed[4];
    logic        eo[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {ovf, data} from the arithmetic meaning of each mode.
    function automatic logic [16:0] model(input logic [15:0] a, input logic [1:0] m, input int w);
        logic [15:0] mask, mn, x, r;
        logic neg, ovf;
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        x    = a & mask;
        mn   = 16'h1 << (w - 1);
        neg  = (m == 2'd1) || (m == 2'd2 && (x & mn) != 16'h0);
        r    = neg ? ((16'h0 - x) & mask) : x;
        ovf  = neg && (x == mn);
`ifdef NEG_SAT_EN
        if (ovf) r = mn - 16'h1;
`endif
        return {ovf, r};
    endfunction

    task automatic mon(input int i, input logic iv, input logic ir, input logic [15:0] a,
                       input logic [1:0] m, input logic ov, input logic [15:0] od,
                       input logic oo, input logic ordy);
        bit exp_v;
        if (!rst_n) begin
            chk($sformatf("rst_out_valid%0d", i), 32'(ov), 32'd0);
            chk($sformatf("rst_out_data%0d", i), 32'(od), 32'd0);
            chk($sformatf("rst_out_ovf%0d", i), 32'(oo), 32'd0);
            pend[i] = 1'b0;
            return;
        end
        if (pend[i]) age[i]++;
        exp_v = pend[i] && (age[i] >= nch[i]);
        chk($sformatf("in_ready%0d", i), 32'(ir), 32'(!pend[i]));
        chk($sformatf("out_valid%0d", i), 32'(ov), 32'(exp_v));
        if (exp_v) begin
            chk($sformatf("out_data%0d", i), 32'(od), 32'(ed[i]));
            chk($sformatf("out_ovf%0d", i), 32'(oo), 32'(eo[i]));
            if (ordy) pend[i] = 1'b0;
        end else if (!pend[i] && iv) begin
            pend[i] = 1'b1;
            age[i]  = -1;
            {eo[i], ed[i]} = model(a, m, wid[i]);
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus0.in_valid, bus0.in_ready, 16'(bus0.in_a), bus0.in_mode, bus0.out_valid,
            16'(bus0.out_data), bus0.out_ovf, bus0.out_ready);
        mon(1, bus1.in_valid, bus1.in_ready, 16'(bus1.in_a), bus1.in_mode, bus1.out_valid,
            16'(bus1.out_data), bus1.out_ovf, bus1.out_ready);
        mon(2, bus2.in_valid, bus2.in_ready, 16'(bus2.in_a), bus2.in_mode, bus2.out_valid,
            16'(bus2.out_data), bus2.out_ovf, bus2.out_ready);
        mon(3, bus3.in_valid, bus3.in_ready, bus3.in_a, bus3.in_mode, bus3.out_valid,
            bus3.out_data, bus3.out_ovf, bus3.out_ready);
    end

    // Waits at negedges for out_valid on the W=8/C=4 unit; cyc counts edges after accept.
    task automatic wait_valid0(output int cyc, output bit got);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            if (bus0.out_valid) got = 1'b1;
            else begin
                @(posedge clk);
                cyc++;
            end
        end
    endtask

    task automatic main_op(input logic [7:0] a, input logic [1:0] m, input logic [7:0] exp_d,
                           input logic exp_o, input string nm);
        int cyc;
        bit got;
        @(posedge clk); #1;
        bus0.in_a = a; bus0.in_mode = m; bus0.in_valid = 1'b1; bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        wait_valid0(cyc, got);
        if (!got) chk({nm, "_timeout"}, 32'd0, 32'd1);
        else begin
            chk({nm, "_latency"}, 32'(cyc), 32'd2);
            chk({nm, "_data"}, 32'(bus0.out_data), 32'(exp_d));
            chk({nm, "_ovf"}, 32'(bus0.out_ovf), 32'(exp_o));
        end
        @(posedge clk); #1;
    endtask

    task automatic sweep_op(input logic [15:0] v, input logic [1:0] m);
        int t;
        @(posedge clk); #1;
        bus0.in_a = v[7:0]; bus1.in_a = v[7:0]; bus2.in_a = v[7:0]; bus3.in_a = v;
        bus0.in_mode = m; bus1.in_mode = m; bus2.in_mode = m; bus3.in_mode = m;
        bus0.in_valid = 1'b1; bus1.in_valid = 1'b1; bus2.in_valid = 1'b1; bus3.in_valid = 1'b1;
        bus0.out_ready = 1'b1; bus1.out_ready = 1'b1; bus2.out_ready = 1'b1; bus3.out_ready = 1'b1;
        @(posedge clk); #1;
        bus0.in_valid = 1'b0; bus1.in_valid = 1'b0; bus2.in_valid = 1'b0; bus3.in_valid = 1'b0;
        t = 0;
        while (!(bus0.in_ready && bus1.in_ready && bus2.in_ready && bus3.in_ready) && t < 30) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 30) chk("sweep_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int cyc;
        bit got;
        logic [7:0] sat_val;
        logic [15:0] v16;
`ifdef NEG_SAT_EN
        sat_val = 8'h7F;
`else
        sat_val = 8'h80;
`endif
        bus0.in_valid = 1'b0; bus1.in_valid = 1'b0; bus2.in_valid = 1'b0; bus3.in_valid = 1'b0;
        bus0.in_a = '0; bus1.in_a = '0; bus2.in_a = '0; bus3.in_a = '0;
        bus0.in_mode = '0; bus1.in_mode = '0; bus2.in_mode = '0; bus3.in_mode = '0;
        bus0.out_ready = 1'b1; bus1.out_ready = 1'b1; bus2.out_ready = 1'b1; bus3.out_ready = 1'b1;

        // Pin the model with hand-computed values.
        chk("model_neg05", 32'(model(16'h0005, 2'd1, 8)), 32'h000FB);
        chk("model_absF6", 32'(model(16'h00F6, 2'd2, 8)), 32'h0000A);
        chk("model_neg80", 32'(model(16'h0080, 2'd1, 8)), {15'd0, 1'b1, 8'h00, sat_val});
        chk("model_w16", 32'(model(16'h0001, 2'd1, 16)), 32'h0FFFF);

        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        #1 chk("reset_in_ready", 32'(bus0.in_ready), 32'd1);
        chk("reset_out_valid", 32'(bus0.out_valid), 32'd0);
        chk("reset_out_data", 32'(bus0.out_data), 32'd0);

        main_op(8'h05, 2'b01, 8'hFB, 1'b0, "neg05");
        main_op(8'hF6, 2'b10, 8'h0A, 1'b0, "absF6");
        main_op(8'h3C, 2'b10, 8'h3C, 1'b0, "abs3C");
        main_op(8'h3C, 2'b00, 8'h3C, 1'b0, "pass3C");
        main_op(8'h3C, 2'b11, 8'h3C, 1'b0, "mode3_3C");
        main_op(8'h80, 2'b01, sat_val, 1'b1, "neg80");
        main_op(8'h80, 2'b10, sat_val, 1'b1, "abs80");
        main_op(8'h00, 2'b01, 8'h00, 1'b0, "neg00");

        // Stall in DONE with a second operand already offered.
        @(posedge clk); #1;
        bus0.in_a = 8'h05; bus0.in_mode = 2'b01; bus0.in_valid = 1'b1; bus0.out_ready = 1'b0;
        @(posedge clk); #1;
        bus0.in_a = 8'h3C; bus0.in_mode = 2'b00;
        wait_valid0(cyc, got);
        if (!got) chk("stall_timeout", 32'd0, 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", 32'(bus0.out_valid), 32'd1);
            chk("stall_data", 32'(bus0.out_data), 32'hFB);
            chk("stall_in_ready", 32'(bus0.in_ready), 32'd0);
            @(negedge clk);
        end
        bus0.out_ready = 1'b1;
        @(negedge clk);
        chk("after_hs_in_ready", 32'(bus0.in_ready), 32'd1);
        chk("after_hs_valid", 32'(bus0.out_valid), 32'd0);
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        chk("second_accepted", 32'(bus0.in_ready), 32'd0);
        wait_valid0(cyc, got);
        if (!got) chk("second_timeout", 32'd0, 32'd1);
        else chk("second_data", 32'(bus0.out_data), 32'h3C);
        @(posedge clk); #1;

        // Reset one cycle after accept discards the operation.
        bus0.in_a = 8'h05; bus0.in_mode = 2'b01; bus0.in_valid = 1'b1;
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1 chk("midrst_valid", 32'(bus0.out_valid), 32'd0);
        chk("midrst_data", 32'(bus0.out_data), 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        #1 chk("midrst_in_ready", 32'(bus0.in_ready), 32'd1);
        chk("midrst_valid_after", 32'(bus0.out_valid), 32'd0);
        main_op(8'h01, 2'b01, 8'hFF, 1'b0, "neg01_after_rst");

        // Full sweep on all configurations; the compare process checks every result.
        for (int v = 0; v < 256; v++) begin
            for (int m = 0; m < 4; m++) begin
                v16 = {8'(v), 8'(v) ^ 8'h3C};
                sweep_op(v16, 2'(m));
            end
        end
        sweep_op(16'h8000, 2'd1);
        sweep_op(16'h8000, 2'd2);
        sweep_op(16'h0000, 2'd1);
        sweep_op(16'hFFFF, 2'd2);
        sweep_op(16'h0001, 2'd1);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
